// File: rtl/regfile_ctrl.sv
// Sequencer/arbiter sharing the 8x16 GPR file between the core (priority) and debug port.
// Runs READ, WRITE and MOVE transactions over a req/ack handshake, one at a time.
module regfile_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [1:0]  core_op,
    input  logic [2:0]  core_ra,
    input  logic [2:0]  core_rb,
    input  logic [15:0] core_wdata,
    output logic        core_ack,
    output logic [15:0] core_rdata,
    input  logic        dbg_req,
    input  logic [1:0]  dbg_op,
    input  logic [2:0]  dbg_ra,
    input  logic [2:0]  dbg_rb,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,
    output logic [2:0]  rf_src_sel,
    output logic [2:0]  rf_dst_sel,
    output logic        rf_in_en,
    output logic [15:0] rf_in,
    input  logic [15:0] rf_src,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    op_t         op_q;
    logic [2:0]  ra_q, rb_q;
    logic [15:0] wdata_q, tmp_q;
    logic        owner_q;
    logic [3:0]  starve_cnt, starve_d;

    logic        grant_any, grant_dbg;
    op_t         sel_op;
    logic [2:0]  sel_ra, sel_rb;
    logic [15:0] sel_wdata;

    // Arbitration: core wins ties unless debug has waited through LIMIT core grants.
    always_comb begin
        grant_any = core_req | dbg_req;
        grant_dbg = dbg_req & (~core_req | (starve_cnt == LIMIT));
        sel_op    = op_t'(grant_dbg ? dbg_op : core_op);
        sel_ra    = grant_dbg ? dbg_ra : core_ra;
        sel_rb    = grant_dbg ? dbg_rb : core_rb;
        sel_wdata = grant_dbg ? dbg_wdata : core_wdata;
    end

    always_comb begin
        starve_d = starve_cnt;
        if (state_q == IDLE && grant_any) begin
            if (grant_dbg || !dbg_req) begin
                starve_d = 4'd0;
            end else if (starve_cnt != LIMIT) begin
                starve_d = starve_cnt + 4'd1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        rf_src_sel = 3'd0;
        rf_dst_sel = 3'd0;
        rf_in_en   = 1'b0;
        rf_in      = 16'h0000;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    unique case (sel_op)
                        OP_READ, OP_MOVE: state_d = RD;
                        OP_WRITE:         state_d = WR;
                        default:          state_d = DONE;
                    endcase
                end
            end
            RD: begin
                rf_src_sel = ra_q;
                state_d    = CAP;
            end
            CAP: begin
                rf_src_sel = ra_q;
                state_d    = (op_q == OP_MOVE) ? WR : DONE;
            end
            WR: begin
                rf_dst_sel = rb_q;
                rf_in_en   = 1'b1;
                rf_in      = (op_q == OP_MOVE) ? tmp_q : wdata_q;
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign core_ack = (state_q == DONE) && !owner_q;
    assign dbg_ack  = (state_q == DONE) && owner_q;
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_READ;
            ra_q       <= 3'd0;
            rb_q       <= 3'd0;
            wdata_q    <= 16'h0000;
            tmp_q      <= 16'h0000;
            owner_q    <= 1'b0;
            starve_cnt <= 4'd0;
            core_rdata <= 16'h0000;
            dbg_rdata  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            starve_cnt <= starve_d;
            if (state_q == IDLE && grant_any) begin
                op_q    <= sel_op;
                ra_q    <= sel_ra;
                rb_q    <= sel_rb;
                wdata_q <= sel_wdata;
                owner_q <= grant_dbg;
                // Reserved ops complete immediately and report zero to their owner.
                if (sel_op == OP_RSVD) begin
                    if (grant_dbg) dbg_rdata  <= 16'h0000;
                    else           core_rdata <= 16'h0000;
                end
            end
            if (state_q == CAP) begin
                tmp_q <= rf_src;
                if (op_q == OP_READ) begin
                    if (owner_q) dbg_rdata  <= rf_src;
                    else         core_rdata <= rf_src;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: register-file model, transaction-level reference model with a
// per-cycle compare process, and directed transactions with hand-computed expectations.
module tb_regfile_ctrl;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, dbg_req;
    logic [1:0]  core_op, dbg_op;
    logic [2:0]  core_ra, core_rb, dbg_ra, dbg_rb;
    logic [15:0] core_wdata, dbg_wdata;
    logic        core_ack, dbg_ack;
    logic [15:0] core_rdata, dbg_rdata;
    logic [2:0]  rf_src_sel, rf_dst_sel;
    logic        rf_in_en;
    logic [15:0] rf_in, rf_src;
    logic        busy, owner;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_ctrl #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_op(core_op), .core_ra(core_ra), .core_rb(core_rb),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_ra(dbg_ra), .dbg_rb(dbg_rb),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .rf_src_sel(rf_src_sel), .rf_dst_sel(rf_dst_sel), .rf_in_en(rf_in_en),
        .rf_in(rf_in), .rf_src(rf_src), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Register file: src registered on posedge, writes on negedge.
    logic [15:0] gpr [8] = '{16'h0000, 16'hFFFF, 16'h1002, 16'h1003,
                             16'h1004, 16'h1005, 16'h1006, 16'h1007};
    always @(posedge clk) rf_src <= gpr[rf_src_sel];
    always @(negedge clk) if (rf_in_en) gpr[rf_dst_sel] <= rf_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return 3;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    // Transaction-level reference model: age counts cycles since the grant cycle.
    logic [15:0] ref_gpr [8] = '{16'h0000, 16'hFFFF, 16'h1002, 16'h1003,
                                 16'h1004, 16'h1005, 16'h1006, 16'h1007};
    bit          m_busy = 1'b0;
    bit          m_owner, m_dbg;
    int          m_age, m_lat, m_starve;
    logic [1:0]  m_op;
    logic [2:0]  m_ra, m_rb;
    logic [15:0] m_wdata, m_val;
    logic [15:0] exp_rdata [2];

    always @(posedge clk) begin
        if (rst) begin
            m_busy       = 1'b0;
            m_owner      = 1'b0;
            m_starve     = 0;
            m_age        = 0;
            exp_rdata[0] = 16'h0000;
            exp_rdata[1] = 16'h0000;
        end else if (m_busy) begin
            if (m_age == m_lat) begin
                m_busy = 1'b0;
                if (m_op == 2'b01)      ref_gpr[m_rb] = m_wdata;
                else if (m_op == 2'b10) ref_gpr[m_rb] = m_val;
            end else begin
                m_age++;
            end
        end else if (core_req || dbg_req) begin
            m_dbg = dbg_req && (!core_req || m_starve == LIM);
            if (m_dbg || !dbg_req) m_starve = 0;
            else if (m_starve < LIM) m_starve++;
            m_owner = m_dbg;
            m_op    = m_dbg ? dbg_op    : core_op;
            m_ra    = m_dbg ? dbg_ra    : core_ra;
            m_rb    = m_dbg ? dbg_rb    : core_rb;
            m_wdata = m_dbg ? dbg_wdata : core_wdata;
            m_val   = ref_gpr[m_ra];
            m_lat   = lat_of(m_op);
            m_age   = 1;
            m_busy  = 1'b1;
        end
        if (!rst && m_busy && m_age == m_lat) begin
            if (m_op == 2'b00)      exp_rdata[m_owner] = m_val;
            else if (m_op == 2'b11) exp_rdata[m_owner] = 16'h0000;
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    bit          chk_en = 1'b0;
    int          en_cycles = 0;
    logic [15:0] last_in = 16'h0000;
    logic [2:0]  e_src, e_dst;
    logic        e_en, e_ack;
    logic [15:0] e_in;

    always @(negedge clk) begin
        if (chk_en) begin
            e_src = 3'd0; e_dst = 3'd0; e_en = 1'b0; e_in = 16'h0000;
            e_ack = m_busy && (m_age == m_lat);
            if (m_busy) begin
                if ((m_op == 2'b00 || m_op == 2'b10) && (m_age == 1 || m_age == 2)) e_src = m_ra;
                if ((m_op == 2'b01 && m_age == 1) || (m_op == 2'b10 && m_age == 3)) begin
                    e_en  = 1'b1;
                    e_dst = m_rb;
                    e_in  = (m_op == 2'b01) ? m_wdata : m_val;
                end
            end
            check("busy",       32'(busy),       32'(m_busy));
            check("core_ack",   32'(core_ack),   32'(e_ack && !m_owner));
            check("dbg_ack",    32'(dbg_ack),    32'(e_ack && m_owner));
            check("owner",      32'(owner),      32'(m_owner));
            check("core_rdata", 32'(core_rdata), 32'(exp_rdata[0]));
            check("dbg_rdata",  32'(dbg_rdata),  32'(exp_rdata[1]));
            check("rf_src_sel", 32'(rf_src_sel), 32'(e_src));
            check("rf_dst_sel", 32'(rf_dst_sel), 32'(e_dst));
            check("rf_in_en",   32'(rf_in_en),   32'(e_en));
            check("rf_in",      32'(rf_in),      32'(e_in));
        end
        if (rf_in_en) begin
            en_cycles++;
            last_in = rf_in;
        end
    end

    // Issue one transaction from the current IDLE cycle (cycle 0); returns ack latency or -1.
    task automatic do_txn(input bit who, input logic [1:0] op, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [15:0] wd, output int lat);
        if (!who) begin
            core_op = op; core_ra = ra; core_rb = rb; core_wdata = wd; core_req = 1'b1;
        end else begin
            dbg_op = op; dbg_ra = ra; dbg_rb = rb; dbg_wdata = wd; dbg_req = 1'b1;
        end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((!who && core_ack) || (who && dbg_ack)) begin
                lat = k;
                break;
            end
        end
        core_req = 1'b0;
        dbg_req  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, base, got, cyc;
        bit want_dbg;
        rst = 1'b1;
        core_req = 1'b0; core_op = 2'b00; core_ra = 3'd0; core_rb = 3'd0; core_wdata = 16'h0;
        dbg_req  = 1'b0; dbg_op  = 2'b00; dbg_ra  = 3'd0; dbg_rb  = 3'd0; dbg_wdata  = 16'h0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        check("rst_busy",       32'(busy),       32'd0);
        check("rst_owner",      32'(owner),      32'd0);
        check("rst_acks",       32'({core_ack, dbg_ack}), 32'd0);
        check("rst_core_rdata", 32'(core_rdata), 32'h0000);
        check("rst_dbg_rdata",  32'(dbg_rdata),  32'h0000);

        do_txn(1'b0, 2'b00, 3'd1, 3'd0, 16'h0, lat);
        check("read_r1_lat",   32'(lat),        32'd3);
        check("read_r1_data",  32'(core_rdata), 32'hFFFF);
        check("read_r1_dbgrd", 32'(dbg_rdata),  32'h0000);

        base = en_cycles;
        do_txn(1'b0, 2'b01, 3'd0, 3'd3, 16'hA5C3, lat);
        check("write_lat",     32'(lat),              32'd2);
        check("write_en_cnt",  32'(en_cycles - base), 32'd1);
        check("write_r3",      32'(gpr[3]),           32'hA5C3);

        do_txn(1'b1, 2'b00, 3'd3, 3'd0, 16'h0, lat);
        check("dbg_read_lat",   32'(lat),       32'd3);
        check("dbg_read_data",  32'(dbg_rdata), 32'hA5C3);
        check("dbg_read_owner", 32'(owner),     32'd1);

        do_txn(1'b0, 2'b01, 3'd0, 3'd2, 16'h1234, lat);
        do_txn(1'b0, 2'b10, 3'd2, 3'd5, 16'h0, lat);
        check("move_lat",   32'(lat),     32'd4);
        check("move_rf_in", 32'(last_in), 32'h1234);
        do_txn(1'b0, 2'b00, 3'd5, 3'd0, 16'h0, lat);
        check("read_r5", 32'(core_rdata), 32'h1234);

        do_txn(1'b0, 2'b10, 3'd4, 3'd4, 16'h0, lat);
        check("move_same_lat", 32'(lat), 32'd4);
        do_txn(1'b0, 2'b00, 3'd4, 3'd0, 16'h0, lat);
        check("read_r4", 32'(core_rdata), 32'h1004);

        // Both requesters held: expect C,C,C,C,D repeating.
        core_op = 2'b00; core_ra = 3'd1; dbg_op = 2'b00; dbg_ra = 3'd3;
        core_req = 1'b1; dbg_req = 1'b1;
        got = 0; cyc = 0;
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (core_ack || dbg_ack) begin
                want_dbg = (got % 5 == 4);
                check("starve_dbg_ack",  32'(dbg_ack),  32'(want_dbg));
                check("starve_core_ack", 32'(core_ack), 32'(!want_dbg));
                got++;
            end
        end
        core_req = 1'b0; dbg_req = 1'b0;
        check("starve_ack_count", 32'(got), 32'd10);
        @(negedge clk);

        base = en_cycles;
        do_txn(1'b1, 2'b11, 3'd2, 3'd6, 16'hBEEF, lat);
        check("rsvd_lat",    32'(lat),              32'd1);
        check("rsvd_rdata",  32'(dbg_rdata),        32'h0000);
        check("rsvd_en_cnt", 32'(en_cycles - base), 32'd0);

        // Reset during the CAP cycle of a core MOVE R1->R6.
        core_op = 2'b10; core_ra = 3'd1; core_rb = 3'd6; core_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1; core_req = 1'b0;
        @(negedge clk);
        check("post_rst_busy",  32'(busy),     32'd0);
        check("post_rst_en",    32'(rf_in_en), 32'd0);
        check("post_rst_ack",   32'(core_ack), 32'd0);
        rst = 1'b0;
        got = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (core_ack) got++;
        end
        check("post_rst_no_ack", 32'(got),    32'd0);
        check("post_rst_r6",     32'(gpr[6]), 32'h1006);
        do_txn(1'b0, 2'b00, 3'd6, 3'd0, 16'h0, lat);
        check("post_rst_read_lat", 32'(lat),        32'd3);
        check("post_rst_read_r6",  32'(core_rdata), 32'h1006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
